// File: rtl/branch_predictor_pkg.sv
// Shared branch-prediction types: PHT counters, PHT index path, BTB entry and predictor FSM state.
package branch_predictor_pkg;

    localparam int PC_WIDTH_DEF      = 32;
    localparam int BTB_ENTRY_NUM_DEF = 64;
    localparam int PHT_ENTRY_NUM_DEF = 256;
    localparam int PHT_INDEX_WIDTH   = $clog2(PHT_ENTRY_NUM_DEF);
    localparam int BTB_TAG_WIDTH     = PC_WIDTH_DEF - 2 - $clog2(BTB_ENTRY_NUM_DEF);

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } BranchPredCounter;

    // Carried alongside the instruction in the pipeline-register structs.
    typedef logic [PHT_INDEX_WIDTH-1:0] PhtIndexPath;

    typedef struct packed {
        logic                     valid;
        logic [BTB_TAG_WIDTH-1:0] tag;
        logic [PC_WIDTH_DEF-1:0]  target;
    } BtbEntry;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } PredState;

    function automatic BranchPredCounter nextCounter(BranchPredCounter c, logic taken, logic isJump);
        BranchPredCounter n;
        n = c;
        if (isJump) begin
            n = STRONG_T;
        end else if (taken) begin
            case (c)
                STRONG_NT: n = WEAK_NT;
                WEAK_NT:   n = WEAK_T;
                default:   n = STRONG_T;
            endcase
        end else begin
            case (c)
                STRONG_T: n = WEAK_T;
                WEAK_T:   n = WEAK_NT;
                default:  n = STRONG_NT;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: synchronous read-first lookup, one write port, sweep-driven valid clear.
module branch_target_buffer #(
    parameter int PC_WIDTH  = 32,
    parameter int ENTRY_NUM = 64,
    localparam int IW = $clog2(ENTRY_NUM),
    localparam int TW = PC_WIDTH - 2 - IW
) (
    input  logic                clk,
    input  logic                rdEn,
    input  logic [PC_WIDTH-1:0] rdPc,
    output logic                rdHit,
    output logic [PC_WIDTH-1:0] rdTarget,
    input  logic                clrEn,
    input  logic [IW-1:0]       clrIdx,
    input  logic                wrEn,
    input  logic [PC_WIDTH-1:0] wrPc,
    input  logic [PC_WIDTH-1:0] wrTarget
);

    logic                valid  [ENTRY_NUM];
    logic [TW-1:0]       tag    [ENTRY_NUM];
    logic [PC_WIDTH-1:0] target [ENTRY_NUM];

    logic [IW-1:0] rdIdx, wrIdx;
    logic          validQ;
    logic [TW-1:0] tagQ, lookupTagQ;
    logic          unusedLowBits;

    assign rdIdx = rdPc[2 +: IW];
    assign wrIdx = wrPc[2 +: IW];
    assign unusedLowBits = ^{rdPc[1:0], wrPc[1:0]};

    // Reads sample the array before this edge's write lands (read-first).
    always_ff @(posedge clk) begin
        if (rdEn) begin
            validQ     <= valid[rdIdx];
            tagQ       <= tag[rdIdx];
            rdTarget   <= target[rdIdx];
            lookupTagQ <= rdPc[PC_WIDTH-1 -: TW];
        end
        if (clrEn) begin
            valid[clrIdx] <= 1'b0;
        end else if (wrEn) begin
            valid[wrIdx]  <= 1'b1;
            tag[wrIdx]    <= wrPc[PC_WIDTH-1 -: TW];
            target[wrIdx] <= wrTarget;
        end
    end

    assign rdHit = validQ && (tagQ == lookupTagQ);

endmodule

// File: rtl/branch_predictor.sv
// Gshare predictor: PHT of 2-bit counters indexed by PC^GHR plus a direct-mapped BTB, trained at resolution.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int PC_WIDTH      = 32,
    parameter int BTB_ENTRY_NUM = 64,
    parameter int PHT_ENTRY_NUM = 256,
    localparam int G = $clog2(PHT_ENTRY_NUM)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic                fetchValid,
    input  logic                fetchStall,
    input  logic [PC_WIDTH-1:0] fetchPc,
    output logic                isBranchTakenPredicted,
    output logic [PC_WIDTH-1:0] predictedNextPC,
    output logic [G-1:0]        predictedPhtIndex,
    input  logic                updateValid,
    input  logic                updateIsJump,
    input  logic [PC_WIDTH-1:0] updatePc,
    input  logic [G-1:0]        updatePhtIndex,
    input  logic                updateTaken,
    input  logic [PC_WIDTH-1:0] updateTarget
);

    localparam int SWEEP_NUM = (BTB_ENTRY_NUM > PHT_ENTRY_NUM) ? BTB_ENTRY_NUM : PHT_ENTRY_NUM;
    localparam int CW        = $clog2(SWEEP_NUM);
    localparam int BI        = $clog2(BTB_ENTRY_NUM);

    PredState         state, stateNext;
    logic [CW-1:0]    initCnt;
    logic             initActive;
    BranchPredCounter pht [PHT_ENTRY_NUM];
    BranchPredCounter rdCtr, phtWData;
    logic             phtWe;
    logic [G-1:0]     phtWIdx, ghr, phtIdx, phtIdxQ;
    logic             lookupOk, btbHit, takenPred;
    logic [PC_WIDTH-1:0] nextPcQ, btbTarget;

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            INIT:    if (initCnt == CW'(SWEEP_NUM - 1)) stateNext = READY;
            default: stateNext = state;
        endcase
    end

    always_comb begin
        ready      = (state == READY);
        initActive = (state == INIT);
    end

    always_ff @(posedge clk) begin
        if (rst)             initCnt <= '0;
        else if (initActive) initCnt <= initCnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)                        ghr <= '0;
        else if (ready && updateValid)  ghr <= {ghr[G-2:0], updateTaken};
    end

    assign phtIdx = fetchPc[2 +: G] ^ ghr;

    always_comb begin
        phtWe    = 1'b0;
        phtWIdx  = updatePhtIndex;
        phtWData = nextCounter(pht[updatePhtIndex], updateTaken, updateIsJump);
        if (initActive) begin
            phtWe    = 32'(initCnt) < PHT_ENTRY_NUM;
            phtWIdx  = initCnt[G-1:0];
            phtWData = WEAK_NT;
        end else if (updateValid) begin
            phtWe = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (phtWe)       pht[phtWIdx] <= phtWData;
        if (!fetchStall) rdCtr <= pht[phtIdx];
    end

    // lookupOk gates the stale memory read data whenever the lookup was idle or outside READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            lookupOk <= 1'b0;
            nextPcQ  <= '0;
            phtIdxQ  <= '0;
        end else if (!fetchStall) begin
            lookupOk <= fetchValid && ready;
            nextPcQ  <= fetchPc + PC_WIDTH'(4);
            phtIdxQ  <= phtIdx;
        end
    end

    branch_target_buffer #(
        .PC_WIDTH  (PC_WIDTH),
        .ENTRY_NUM (BTB_ENTRY_NUM)
    ) btb (
        .clk      (clk),
        .rdEn     (!fetchStall),
        .rdPc     (fetchPc),
        .rdHit    (btbHit),
        .rdTarget (btbTarget),
        .clrEn    (initActive && (32'(initCnt) < BTB_ENTRY_NUM)),
        .clrIdx   (initCnt[BI-1:0]),
        .wrEn     (ready && updateValid && updateTaken),
        .wrPc     (updatePc),
        .wrTarget (updateTarget)
    );

    assign takenPred              = lookupOk && btbHit && rdCtr[1];
    assign isBranchTakenPredicted = takenPred;
    assign predictedNextPC        = takenPred ? btbTarget : nextPcQ;
    assign predictedPhtIndex      = phtIdxQ;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: init sweep, counter training, aliasing, stall hold, read-first.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst, ready, fetchValid, fetchStall;
    logic [31:0] fetchPc, predictedNextPC, updatePc, updateTarget;
    logic        isBranchTakenPredicted, updateValid, updateIsJump, updateTaken;
    logic [7:0]  predictedPhtIndex, updatePhtIndex;

    int nChk = 0;
    int nPass = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk                    (clk),
        .rst                    (rst),
        .ready                  (ready),
        .fetchValid             (fetchValid),
        .fetchStall             (fetchStall),
        .fetchPc                (fetchPc),
        .isBranchTakenPredicted (isBranchTakenPredicted),
        .predictedNextPC        (predictedNextPC),
        .predictedPhtIndex      (predictedPhtIndex),
        .updateValid            (updateValid),
        .updateIsJump           (updateIsJump),
        .updatePc               (updatePc),
        .updatePhtIndex         (updatePhtIndex),
        .updateTaken            (updateTaken),
        .updateTarget           (updateTarget)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChk++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic predChk(input string tag, input logic taken, input logic [31:0] npc, input logic [7:0] idx);
        chk({tag, ".taken"}, 32'(isBranchTakenPredicted), 32'(taken));
        chk({tag, ".npc"}, predictedNextPC, npc);
        chk({tag, ".idx"}, 32'(predictedPhtIndex), 32'(idx));
    endtask

    task automatic lookup(input logic [31:0] pc);
        fetchValid = 1'b1;
        fetchPc    = pc;
        tick();
        fetchValid = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [7:0] idx, input logic taken,
                       input logic jump, input logic [31:0] tgt);
        updateValid    = 1'b1;
        updatePc       = pc;
        updatePhtIndex = idx;
        updateTaken    = taken;
        updateIsJump   = jump;
        updateTarget   = tgt;
        tick();
        updateValid = 1'b0;
    endtask

    // Eight not-taken resolutions on a scratch counter shift the GHR back to zero.
    task automatic flushGhr();
        repeat (8) upd(32'h0, 8'h01, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; fetchValid = 1'b1; fetchStall = 1'b0; fetchPc = 32'h100;
        updateValid = 1'b0; updateIsJump = 1'b0; updatePc = '0;
        updatePhtIndex = '0; updateTaken = 1'b0; updateTarget = '0;
        tick();
        tick();
        chk("rst.ready", 32'(ready), 0);
        predChk("rst", 1'b0, 32'h0, 8'h00);
        rst = 1'b0;

        for (int k = 1; k <= 256; k++) begin
            tick();
            chk("init.ready", 32'(ready), (k == 256) ? 1 : 0);
            predChk("init", 1'b0, 32'h104, 8'h40);
        end
        tick();
        predChk("firstReady", 1'b0, 32'h104, 8'h40);
        fetchValid = 1'b0;

        // Train 0x200 -> 0x80 twice: counter 01 -> 10 -> 11
        lookup(32'h200);
        predChk("cold200", 1'b0, 32'h204, 8'h80);
        upd(32'h200, 8'h80, 1'b1, 1'b0, 32'h80);
        upd(32'h200, 8'h80, 1'b1, 1'b0, 32'h80);
        flushGhr();
        lookup(32'h200);
        predChk("trained200", 1'b1, 32'h80, 8'h80);

        // Saturating decrement 11 -> 10 -> 01 -> 00, then stays 00
        upd(32'h200, 8'h80, 1'b0, 1'b0, 32'h0);
        lookup(32'h200);
        predChk("dec10", 1'b1, 32'h80, 8'h80);
        upd(32'h200, 8'h80, 1'b0, 1'b0, 32'h0);
        lookup(32'h200);
        predChk("dec01", 1'b0, 32'h204, 8'h80);
        upd(32'h200, 8'h80, 1'b0, 1'b0, 32'h0);
        lookup(32'h200);
        predChk("dec00", 1'b0, 32'h204, 8'h80);
        upd(32'h200, 8'h80, 1'b0, 1'b0, 32'h0);
        upd(32'h200, 8'h80, 1'b1, 1'b0, 32'h80);
        flushGhr();
        lookup(32'h200);
        predChk("satLow", 1'b0, 32'h204, 8'h80);

        // Tag mismatch on same BTB index (counter now 10, GHR=1)
        upd(32'h200, 8'h80, 1'b1, 1'b0, 32'h80);
        lookup(32'h10200);
        predChk("alias", 1'b0, 32'h10204, 8'h81);

        // Stall holds outputs while fetchPc moves
        flushGhr();
        lookup(32'h200);
        predChk("preStall", 1'b1, 32'h80, 8'h80);
        fetchStall = 1'b1;
        fetchValid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            fetchPc = 32'h400 + 32'(s) * 32'h100;
            tick();
            predChk("stall", 1'b1, 32'h80, 8'h80);
        end
        fetchStall = 1'b0;
        fetchValid = 1'b0;
        fetchPc    = 32'h200;
        tick();
        predChk("idle", 1'b0, 32'h204, 8'h80);

        // Same-cycle lookup and update of 0x300: lookup sees old state
        fetchValid = 1'b1; fetchPc = 32'h300;
        upd(32'h300, 8'hC0, 1'b1, 1'b0, 32'h1234);
        fetchValid = 1'b0;
        predChk("readFirst", 1'b0, 32'h304, 8'hC0);
        flushGhr();
        lookup(32'h300);
        predChk("afterWrite", 1'b1, 32'h1234, 8'hC0);

        // +4 wraps modulo 2^32
        lookup(32'hFFFF_FFFC);
        predChk("wrap", 1'b0, 32'h0, 8'hFF);

        // Jump forces STRONG_T: one not-taken afterwards still predicts taken
        upd(32'h500, 8'h40, 1'b1, 1'b1, 32'h900);
        upd(32'h500, 8'h40, 1'b0, 1'b0, 32'h0);
        flushGhr();
        lookup(32'h500);
        predChk("jump", 1'b1, 32'h900, 8'h40);

        // Mid-run reset restarts the sweep
        rst = 1'b1;
        tick();
        chk("rst2.ready", 32'(ready), 0);
        predChk("rst2", 1'b0, 32'h0, 8'h00);
        rst = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            tick();
            if (k >= 255) chk("init2.ready", 32'(ready), (k == 256) ? 1 : 0);
        end
        lookup(32'h500);
        predChk("postInit", 1'b0, 32'h504, 8'h40);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
